// File: rtl/sfx_feed_sched_if.sv
// sfx_feed_sched_if: sample-memory read port and PCM FIFO write port of the refill scheduler
// master (scheduler): drives mem_req/mem_addr and pcm_we/pcm_chan/pcm_dat, samples mem_ack/mem_dat
// slave (memory + channel FIFOs): the opposite directions
interface sfx_feed_sched_if #(
    parameter int AW = 24,
    parameter int CW = 3
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [15:0]   mem_dat;
    logic          pcm_we;
    logic [CW-1:0] pcm_chan;
    logic [15:0]   pcm_dat;
    modport master (
        output mem_req, mem_addr, pcm_we, pcm_chan, pcm_dat,
        input  mem_ack, mem_dat
    );
    modport slave (
        input  mem_req, mem_addr, pcm_we, pcm_chan, pcm_dat,
        output mem_ack, mem_dat
    );
endinterface

// File: rtl/sfx_feed_sched.sv
// sfx_feed_sched: round-robin sample refill scheduler for the PCM channels of one sfx bank
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cfg_we/chan/start/len/loop     start a voice (len 0 ignored)
//   stop_we/stop_chan              stop a voice
//   fifo_full                      per-channel FIFO full
//   bus (master)                   mem_req/addr/ack/dat read port, pcm_we/chan/dat FIFO write
//   active                         voice running per channel
//   done                           one-cycle pulse when a non-loop voice ends
module sfx_feed_sched #(
    parameter int NCHAN = 8,
    parameter int AW    = 24,
    parameter int LW    = 16,
    localparam int CW   = $clog2(NCHAN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_chan,
    input  logic [AW-1:0]    cfg_start,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_loop,
    input  logic             stop_we,
    input  logic [CW-1:0]    stop_chan,
    input  logic [NCHAN-1:0] fifo_full,
    sfx_feed_sched_if.master bus,
    output logic [NCHAN-1:0] active,
    output logic [NCHAN-1:0] done
);
    typedef enum logic [1:0] {IDLE, REQ, WR, HOLD} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick, cand;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0] dat_q, dat_d;
    logic kill_q, kill_d, kill, found, hit, cfg_acc, last, pcm_we;
    logic [NCHAN-1:0] active_q, active_d, loop_q, loop_d, elig;
    logic [AW-1:0] cur_q [NCHAN], cur_d [NCHAN], start_q [NCHAN], start_d [NCHAN];
    logic [LW-1:0] rem_q [NCHAN], rem_d [NCHAN], len_q [NCHAN], len_d [NCHAN];
    // stop on the same channel overrides a simultaneous start
    assign cfg_acc = cfg_we && cfg_len != '0 && !(stop_we && stop_chan == cfg_chan);
    assign hit = (cfg_acc && cfg_chan == sel_q) || (stop_we && stop_chan == sel_q);
    // a reconfigure/stop landing in the write cycle itself still suppresses that write
    assign kill = kill_q || (state_q == WR && hit);
    assign last = rem_q[sel_q] == LW'(1);
    assign pcm_we = state_q == WR && !kill;
    assign elig = active_q & ~fifo_full;
    assign active = active_q;
    assign done = (pcm_we && last && !loop_q[sel_q]) ? NCHAN'(1) << sel_q : '0;
    assign bus.mem_req = state_q == REQ;
    assign bus.mem_addr = addr_q;
    assign bus.pcm_we = pcm_we;
    assign bus.pcm_chan = pcm_we ? sel_q : '0;
    assign bus.pcm_dat = pcm_we ? dat_q : '0;
    // iterate from the farthest offset down so the nearest eligible channel wins
    always_comb begin
        found = 1'b0;
        pick = '0;
        cand = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            cand = rr_ptr_q + CW'(i);
            if (elig[cand]) begin
                found = 1'b1;
                pick = cand;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        addr_d = addr_q;
        dat_d = dat_q;
        kill_d = kill_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = REQ;
                sel_d = pick;
                addr_d = cur_q[pick];
                kill_d = 1'b0;
            end
            REQ: begin
                kill_d = kill_q || hit;
                if (bus.mem_ack) begin
                    state_d = WR;
                    dat_d = bus.mem_dat;
                end
            end
            WR: begin
                state_d = HOLD;
                rr_ptr_d = sel_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cur_d = cur_q;
        rem_d = rem_q;
        start_d = start_q;
        len_d = len_q;
        loop_d = loop_q;
        active_d = active_q;
        if (pcm_we) begin
            cur_d[sel_q] = cur_q[sel_q] + AW'(1);
            rem_d[sel_q] = rem_q[sel_q] - LW'(1);
            if (last && loop_q[sel_q]) begin
                cur_d[sel_q] = start_q[sel_q];
                rem_d[sel_q] = len_q[sel_q];
            end
            if (last && !loop_q[sel_q]) active_d[sel_q] = 1'b0;
        end
        if (cfg_acc) begin
            cur_d[cfg_chan] = cfg_start;
            start_d[cfg_chan] = cfg_start;
            rem_d[cfg_chan] = cfg_len;
            len_d[cfg_chan] = cfg_len;
            loop_d[cfg_chan] = cfg_loop;
            active_d[cfg_chan] = 1'b1;
        end
        if (stop_we) active_d[stop_chan] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q <= '0;
            addr_q <= '0;
            dat_q <= '0;
            kill_q <= 1'b0;
            rr_ptr_q <= '0;
            active_q <= '0;
            loop_q <= '0;
            cur_q <= '{default: '0};
            start_q <= '{default: '0};
            rem_q <= '{default: '0};
            len_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            addr_q <= addr_d;
            dat_q <= dat_d;
            kill_q <= kill_d;
            rr_ptr_q <= rr_ptr_d;
            active_q <= active_d;
            loop_q <= loop_d;
            cur_q <= cur_d;
            start_q <= start_d;
            rem_q <= rem_d;
            len_q <= len_d;
        end
    end
endmodule

// File: tb/tb_sfx_feed_sched.sv
// tb_sfx_feed_sched: directed self-checking bench for the refill scheduler
module tb_sfx_feed_sched;
    logic clk = 1'b0;
    logic rst, cfg_we, cfg_loop, stop_we;
    logic [2:0] cfg_chan, stop_chan;
    logic [23:0] cfg_start;
    logic [15:0] cfg_len;
    logic [7:0] fifo_full, active, done;
    int checks = 0, errors = 0, cyc = 0;
    int w0, w1, w2;
    sfx_feed_sched_if #(.AW(24), .CW(3)) bus();
    sfx_feed_sched dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_start(cfg_start),
        .cfg_len(cfg_len), .cfg_loop(cfg_loop), .stop_we(stop_we), .stop_chan(stop_chan),
        .fifo_full(fifo_full), .bus(bus), .active(active), .done(done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic do_reset;
        rst = 1'b1;
        cfg_we = 1'b0;
        stop_we = 1'b0;
        cfg_chan = '0;
        stop_chan = '0;
        cfg_start = '0;
        cfg_len = '0;
        cfg_loop = 1'b0;
        fifo_full = '0;
        bus.mem_ack = 1'b0;
        bus.mem_dat = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask
    task automatic cfg(input logic [2:0] ch, input logic [23:0] a, input logic [15:0] n, input logic lp);
        cfg_we = 1'b1;
        cfg_chan = ch;
        cfg_start = a;
        cfg_len = n;
        cfg_loop = lp;
        tick;
        cfg_we = 1'b0;
    endtask
    task automatic wait_req;
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("req_seen", bus.mem_req, 1);
    endtask
    // wait for a request, ack it at once, then check the write that follows
    task automatic serve(input logic [23:0] a, input logic [2:0] ch, input logic [15:0] d,
                         input logic dn, output int wc);
        wait_req;
        chk("mem_addr", bus.mem_addr, a);
        bus.mem_ack = 1'b1;
        bus.mem_dat = d;
        tick;
        bus.mem_ack = 1'b0;
        chk("pcm_we", bus.pcm_we, 1);
        chk("pcm_chan", bus.pcm_chan, ch);
        chk("pcm_dat", bus.pcm_dat, d);
        chk("done", done, dn ? (8'b1 << ch) : 8'b0);
        wc = cyc;
    endtask
    initial begin
        do_reset;
        chk("rst_req", bus.mem_req, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_pcm_we", bus.pcm_we, 0);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        // single non-looping voice
        cfg(3'd2, 24'h000100, 16'd3, 1'b0);
        chk("sv_active", active, 8'h04);
        serve(24'h000100, 3'd2, 16'h1111, 1'b0, w0);
        serve(24'h000101, 3'd2, 16'h2222, 1'b0, w1);
        serve(24'h000102, 3'd2, 16'h3333, 1'b1, w2);
        chk("sv_gap1", w1 - w0, 4);
        chk("sv_gap2", w2 - w1, 4);
        tick;
        chk("sv_inactive", active, 0);
        chk("sv_done_clr", done, 0);
        // looping voice
        do_reset;
        cfg(3'd0, 24'h000040, 16'd2, 1'b1);
        serve(24'h000040, 3'd0, 16'h0a00, 1'b0, w0);
        serve(24'h000041, 3'd0, 16'h0a01, 1'b0, w0);
        serve(24'h000040, 3'd0, 16'h0a02, 1'b0, w0);
        serve(24'h000041, 3'd0, 16'h0a03, 1'b0, w0);
        serve(24'h000040, 3'd0, 16'h0a04, 1'b0, w0);
        chk("loop_active", active, 8'h01);
        // round-robin across channels 1, 3, 6
        do_reset;
        cfg(3'd1, 24'h000010, 16'd100, 1'b0);
        cfg(3'd3, 24'h000030, 16'd100, 1'b0);
        cfg(3'd6, 24'h000060, 16'd100, 1'b0);
        serve(24'h000010, 3'd1, 16'hb001, 1'b0, w0);
        serve(24'h000030, 3'd3, 16'hb003, 1'b0, w0);
        serve(24'h000060, 3'd6, 16'hb006, 1'b0, w0);
        serve(24'h000011, 3'd1, 16'hb011, 1'b0, w0);
        serve(24'h000031, 3'd3, 16'hb013, 1'b0, w0);
        serve(24'h000061, 3'd6, 16'hb016, 1'b0, w0);
        fifo_full = 8'h08;
        serve(24'h000012, 3'd1, 16'hc001, 1'b0, w0);
        serve(24'h000062, 3'd6, 16'hc006, 1'b0, w0);
        serve(24'h000013, 3'd1, 16'hc011, 1'b0, w0);
        serve(24'h000063, 3'd6, 16'hc016, 1'b0, w0);
        fifo_full = 8'h00;
        serve(24'h000014, 3'd1, 16'hd001, 1'b0, w0);
        serve(24'h000032, 3'd3, 16'hd003, 1'b0, w0);
        // stop during a slow fetch kills its write
        do_reset;
        cfg(3'd5, 24'h000500, 16'd10, 1'b0);
        wait_req;
        chk("kill_addr", bus.mem_addr, 24'h000500);
        tick;
        stop_we = 1'b1;
        stop_chan = 3'd5;
        tick;
        stop_we = 1'b0;
        tick;
        tick;
        tick;
        chk("kill_req_held", bus.mem_req, 1);
        chk("kill_active", active, 0);
        bus.mem_ack = 1'b1;
        bus.mem_dat = 16'hdead;
        tick;
        bus.mem_ack = 1'b0;
        chk("kill_pcm_we", bus.pcm_we, 0);
        chk("kill_done", done, 0);
        chk("kill_req_drop", bus.mem_req, 0);
        repeat (6) tick;
        chk("kill_idle", bus.mem_req, 0);
        // reset in the middle of a request, then a stray ack
        do_reset;
        cfg(3'd4, 24'h000400, 16'd5, 1'b0);
        wait_req;
        rst = 1'b1;
        tick;
        chk("mrst_req", bus.mem_req, 0);
        chk("mrst_addr", bus.mem_addr, 0);
        chk("mrst_pcm_we", bus.pcm_we, 0);
        chk("mrst_active", active, 0);
        chk("mrst_done", done, 0);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_dat = 16'hbeef;
        tick;
        bus.mem_ack = 1'b0;
        chk("stray_pcm_we", bus.pcm_we, 0);
        chk("stray_pcm_dat", bus.pcm_dat, 0);
        tick;
        chk("stray_req", bus.mem_req, 0);
        // zero-length start is ignored
        cfg(3'd3, 24'h000300, 16'd0, 1'b0);
        chk("len0_active", active, 0);
        repeat (4) tick;
        chk("len0_req", bus.mem_req, 0);
        // address wraps at the top of memory
        cfg(3'd7, 24'hffffff, 16'd2, 1'b0);
        serve(24'hffffff, 3'd7, 16'he000, 1'b0, w0);
        serve(24'h000000, 3'd7, 16'he001, 1'b1, w0);
        tick;
        chk("wrap_inactive", active, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
